// File: rtl/lfsr_pkg.sv
// Shared widths, register offsets and byte-packing helper for the LFSR datapath.
package lfsr_pkg;

  localparam int unsigned LFSR_BYTE_W    = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned DROP_CNT_W     = 8;
  localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  // Register map offsets; 0x10 becomes reachable once the address width grows.
  localparam logic [7:0] REG_LFSR_DATA_OFFSET   = 8'h0C;
  localparam logic [7:0] REG_PACK_STATUS_OFFSET = 8'h10;

  typedef logic [WORD_W-1:0]      word_t;
  typedef logic [LFSR_BYTE_W-1:0] lfsr_byte_t;
  typedef logic [BYTE_IDX_W-1:0]  byte_idx_t;

  // Little-endian lane insert: byte k occupies bits [8k+7:8k].
  function automatic word_t insert_byte(word_t w, byte_idx_t idx, lfsr_byte_t b);
    word_t r;
    r = w;
    r[int'(idx) * LFSR_BYTE_W +: LFSR_BYTE_W] = b;
    return r;
  endfunction

endpackage

// File: rtl/lfsr_word_fifo.sv
// Synchronous word FIFO with explicit level counter; a push into a full FIFO is
// accepted when a pop happens on the same edge.
module lfsr_word_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/lfsr_word_packer.sv
// Packs LFSR bytes into 32-bit words, buffers them and streams them out over
// AXI-Stream with per-packet tlast, reporting level, overflow and drops.
module lfsr_word_packer
  import lfsr_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PKT_WORDS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LFSR_BYTE_W-1:0]   sample_in,
  input  logic                     sample_valid,
  input  logic                     clear,
  output logic [WORD_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_CNT_W-1:0]    drop_count
);

  localparam int unsigned PktCntW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

  logic                  soft_rst;
  byte_idx_t             byte_idx_q, byte_idx_d;
  word_t                 acc_q, acc_d;
  word_t                 packed_word;
  logic [PktCntW-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  word_done, pop, drop;
  logic                  fifo_full, fifo_empty;

  assign soft_rst    = rst | clear;
  assign packed_word = insert_byte(acc_q, byte_idx_q, sample_in);
  assign word_done   = sample_valid && (byte_idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tlast  = m_axis_tvalid && (pkt_cnt_q == PktCntW'(PKT_WORDS - 1));
  assign pop           = m_axis_tvalid && m_axis_tready;
  // Full with a same-cycle pop still accepts, so only a stalled full FIFO drops.
  assign drop          = word_done && fifo_full && !pop;

  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

  lfsr_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (soft_rst),
    .push      (word_done),
    .push_data (packed_word),
    .pop       (pop),
    .pop_data  (m_axis_tdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  always_comb begin
    byte_idx_d = byte_idx_q;
    acc_d      = acc_q;
    pkt_cnt_d  = pkt_cnt_q;
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;

    if (sample_valid) begin
      byte_idx_d = byte_idx_q + 1'b1;
      acc_d      = packed_word;
    end

    if (pop) begin
      pkt_cnt_d = m_axis_tlast ? '0 : pkt_cnt_q + 1'b1;
    end

    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      byte_idx_q <= '0;
      acc_q      <= '0;
      pkt_cnt_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      acc_q      <= acc_d;
      pkt_cnt_q  <= pkt_cnt_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_lfsr_word_packer.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_lfsr_word_packer;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned PKT_WORDS = 4;

  logic        clk = 1'b0;
  logic        rst, clear, sample_valid, tready;
  logic [7:0]  sample_in;
  logic [31:0] tdata;
  logic        tvalid, tlast, overflow;
  logic [3:0]  level;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  lfsr_word_packer #(
    .DEPTH     (DEPTH),
    .PKT_WORDS (PKT_WORDS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .clear         (clear),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .level         (level),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: delivered-word queue, pending bytes, delivery count.
  logic [31:0] m_q[$];
  logic [7:0]  m_bytes[$];
  int          m_deliv;
  bit          m_ovf;
  int          m_drops;

  int          obs_deliv;
  logic [31:0] obs_last_mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit          do_pop;
    bit          have_word;
    int          pre;
    logic [31:0] w;
    if (rst || clear) begin
      m_q.delete();
      m_bytes.delete();
      m_deliv = 0;
      m_ovf   = 0;
      m_drops = 0;
      return;
    end
    pre       = m_q.size();
    do_pop    = (pre > 0) && tready;
    have_word = 0;
    w         = '0;
    if (sample_valid) begin
      m_bytes.push_back(sample_in);
      if (m_bytes.size() == 4) begin
        w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
        have_word = 1;
        m_bytes.delete();
      end
    end
    if (do_pop) begin
      void'(m_q.pop_front());
      m_deliv++;
    end
    if (have_word) begin
      if (pre < int'(DEPTH) || do_pop) m_q.push_back(w);
      else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
    end
  endtask

  // Compare outputs against the model, then advance one clock.
  task automatic cycle();
    bit ev;
    ev = m_q.size() > 0;
    check("tvalid", 32'(tvalid), 32'(ev));
    check("tlast", 32'(tlast), 32'(ev && (m_deliv % PKT_WORDS == PKT_WORDS - 1)));
    check("level", 32'(level), 32'(m_q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_count", 32'(drop_count), 32'(m_drops));
    if (ev) check("tdata", tdata, m_q[0]);
    if (tvalid && tready) begin
      obs_deliv++;
      if (tlast && obs_deliv <= 32) obs_last_mask[obs_deliv-1] = 1'b1;
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic send(input logic [7:0] b);
    sample_valid = 1'b1;
    sample_in    = b;
    cycle();
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    obs_deliv     = 0;
    obs_last_mask = '0;
  endtask

  initial begin
    int bias;
    rst = 1'b1; clear = 1'b0; sample_valid = 1'b0; sample_in = '0; tready = 1'b0;
    obs_deliv = 0; obs_last_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    model_step();
    rst = 1'b0;

    check("reset_tvalid", 32'(tvalid), 32'd0);
    check("reset_tlast", 32'(tlast), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_drop_count", 32'(drop_count), 32'd0);

    // Pack order, back-to-back bytes.
    tready = 1'b1;
    send(8'h19); send(8'h32); send(8'h64);
    check("pack_tvalid_before_4th", 32'(tvalid), 32'd0);
    send(8'hC8);
    check("pack_tvalid", 32'(tvalid), 32'd1);
    check("pack_tdata", tdata, 32'hC864_3219);
    check("pack_tlast", 32'(tlast), 32'd0);
    idle(2);

    // Same bytes with idle gaps.
    send(8'h19); idle(3); send(8'h32); idle(3); send(8'h64); idle(3); send(8'hC8);
    check("gap_tdata", tdata, 32'hC864_3219);
    idle(1);
    check("gap_single_push", 32'(tvalid), 32'd0);

    // Overflow with a stalled consumer.
    tready = 1'b0;
    for (int i = 0; i < 40; i++) send(8'(i));
    check("ovf_level", 32'(level), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_drops", 32'(drop_count), 32'd2);
    tready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("ovf_drain_tdata", tdata,
            {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)});
      cycle();
    end
    check("ovf_drained", 32'(tvalid), 32'd0);

    // Full FIFO with a pop on the same edge as the completing byte.
    tready = 1'b0;
    for (int i = 0; i < 35; i++) send(8'(i));
    check("fullpop_level_before", 32'(level), 32'd8);
    tready = 1'b1;
    send(8'd35);
    check("fullpop_level", 32'(level), 32'd8);
    check("fullpop_drops", 32'(drop_count), 32'd2);
    idle(10);

    // Packet framing over 8 continuous words.
    do_reset();
    tready = 1'b1;
    for (int i = 0; i < 32; i++) send(8'($urandom));
    idle(4);
    check("frame_delivered", 32'(obs_deliv), 32'd8);
    check("frame_tlast_mask", obs_last_mask, 32'h0000_0088);

    // Backpressure on word 3: output held stable.
    do_reset();
    tready = 1'b1;
    for (int i = 0; i < 8; i++) send(8'(i));
    idle(1);
    tready = 1'b0;
    for (int i = 8; i < 12; i++) send(8'(i));
    for (int c = 0; c < 5; c++) begin
      check("stall_tvalid", 32'(tvalid), 32'd1);
      check("stall_tdata", tdata, 32'h0B0A_0908);
      check("stall_tlast", 32'(tlast), 32'd0);
      cycle();
    end
    tready = 1'b1;
    idle(3);

    // Clear mid-word and mid-packet, with a sample on the clear cycle.
    do_reset();
    tready = 1'b1;
    for (int i = 0; i < 8; i++) send(8'(8'h40 + i));
    send(8'hAA); send(8'hBB);
    clear = 1'b1; sample_valid = 1'b1; sample_in = 8'hCC;
    cycle();
    clear = 1'b0; sample_valid = 1'b0;
    obs_deliv = 0; obs_last_mask = '0;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    check("clear_tdata", tdata, 32'h0403_0201);
    check("clear_overflow", 32'(overflow), 32'd0);
    check("clear_drops", 32'(drop_count), 32'd0);
    for (int i = 5; i < 17; i++) send(8'(i));
    idle(3);
    check("clear_delivered", 32'(obs_deliv), 32'd4);
    check("clear_tlast_mask", obs_last_mask, 32'h0000_0008);

    // Drop counter saturation.
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 1200; i++) send(8'($urandom));
    check("sat_drops", 32'(drop_count), 32'd255);
    check("sat_overflow", 32'(overflow), 32'd1);

    // Randomized traffic with varying backpressure and occasional clears.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 0) bias = $urandom_range(5, 95);
      sample_valid = ($urandom_range(0, 3) != 0);
      sample_in    = 8'($urandom);
      tready       = ($urandom_range(0, 99) < bias);
      clear        = ($urandom_range(0, 299) == 0);
      cycle();
    end
    clear = 1'b0; sample_valid = 1'b0; tready = 1'b1;
    idle(12);
    check("final_empty", 32'(tvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
